bcd_seg_scan: RTL
=================

// Module: bcd_seg_scan
// PURPOSE
//  Downstream display stage for the 3-digit BCD counter: snapshots its packed BCD value (q) on an
//  update strobe and drives a time-multiplexed common-anode 7-segment display, one digit per scan slot.
//  Feeds board pins directly; all outputs registered.
// PARAMETERS
//  DIGITS     3      number of BCD digits / display positions (bcd_in is 4*DIGITS wide, digit 0 = LS nibble)
//  SCAN_DIV   50000  clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range >= 2
//  DIV_W      16     width of scan divider counter; must satisfy 2**DIV_W >= SCAN_DIV
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  upd        in   1         snapshot strobe; 1-cycle pulse or level, bcd_in captured on every clk with upd=1
//  bcd_in     in   4*DIGITS  packed BCD value from counter, nibble i = digit i
//  sel        out  DIGITS    digit enables, one-hot active-low (0 = digit on)
//  seg        out  8         segments active-low, {dp,g,f,e,d,c,b,a}; dp always 1 (off)
//  scan_tick  out  1         1-cycle pulse when slot advances (debug/sync)
// BEHAVIOUR
//  Reset (async, rst=1): snap=0, div=0, idx=0, scan_tick=0, sel={DIGITS{1}} (all off), seg=8'hFF.
//  Snapshot: snap <= bcd_in on each clk with upd=1, else hold; bcd_in changes without upd never reach display.
//  Divider: div counts 0..SCAN_DIV-1, wraps to 0; scan_tick=1 registered in the cycle div==SCAN_DIV-1 -> 0.
//  Slot index: idx advances on the same edge div wraps; idx DIGITS-1 -> 0 (wrap); no other transitions.
//  Output register: every clk, sel <= ~(1<<idx), seg <= decode(snap[4*idx+:4], blank(idx)).
//   Latency: sel/seg reflect idx and snap one clk after they change; first valid digit-0 drive 1 clk after rst falls.
//  Decode (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; nibble A..F -> dash 8'hBF; blank -> 8'hFF.
//  Simultaneous upd and slot advance: both take effect on same edge; next output register uses new snap and new idx.
//  upd held high: display tracks bcd_in with 2-clk latency (snap + output reg).
//  Reset mid-scan: everything returns to reset values immediately; scan restarts at digit 0, div=0.
//  No tearing: a digit value changes only via snap, so all digits of one frame come from one snapshot
//   unless upd arrives mid-frame (accepted; upstream pulses upd once per count change).
// CONFIGURATION
//  Macro BCD_SEG_LZ_BLANK_EN:
//   defined:   leading-zero blanking; digit i (i>0) blanked (seg=FF) if snap nibbles i..DIGITS-1 are all 0;
//              digit 0 never blanked; invalid nibble (>9) counts as non-zero. sel still scans normally.
//   undefined: blank(idx)=0 always; all digits show their value including leading zeros.
// STRUCTURE
//  Shared header bcd_seg_defs.vh: SEG_0..SEG_9, SEG_DASH (8'hBF), SEG_BLANK (8'hFF) active-low constants.
//  Sub-module seg7_decode: combinational nibble+blank -> seg code using the header constants; instantiated once
//   on the idx-selected nibble. Divider, idx, snapshot, blank mask and output regs live in bcd_seg_scan.
// TESTING (bench uses DIGITS=3, SCAN_DIV=4, 20 ns clk, both with and without BCD_SEG_LZ_BLANK_EN)
//  1 rst=1 any time -> sel=3'b111, seg=8'hFF, scan_tick=0 same cycle (async); rst=0 -> next clk sel=3'b110.
//  2 bcd_in=12'h123, upd 1-cycle pulse -> over 3 slots: sel 110/seg B0, 101/A4, 011/F9; sel wraps to 110
//    after 12 clks; scan_tick pulses every 4 clks.
//  3 bcd_in changed to 12'h999 with upd=0 -> display stays 1,2,3 for 5 full frames; then upd pulse -> 9,9,9 (90).
//  4 bcd_in=12'h1A3, upd -> digit1 seg=8'hBF (dash), digits 0/2 = B0/F9.
//  5 bcd_in=12'h007, upd -> macro on: digits 2,1 seg=FF, digit0 F8; macro off: C0,C0,F8. 12'h000 macro on: only digit0 C0.
//  6 upd on same edge as slot advance, then rst pulse mid-slot 2 -> new value shown from next slot;
//    after rst scan restarts digit 0, snap=0 (seg C0 or per 5 blanking).

Source files
------------

// File: rtl/bcd_seg_scan_pkg.sv
// Shared types and active-low segment codes for the BCD scan display.
// Bit order of every code is {dp,g,f,e,d,c,b,a}; dp is always off.
package bcd_seg_scan_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_DASH  = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  // Index width that stays legal for a single-digit build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Counter-to-display bus: snapshot strobe and packed BCD in, scan drive out.
interface bcd_seg_scan_if #(
  parameter int DIGITS = 3
);
  logic                  upd;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     sel;
  logic [7:0]            seg;
  logic                  scan_tick;

  modport master (
    output upd, bcd_in,
    input  sel, seg, scan_tick
  );

  modport slave (
    input  upd, bcd_in,
    output sel, seg, scan_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment code; invalid nibbles show a dash.
module seg7_decode
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Snapshots a packed BCD value and scans it onto a multiplexed common-anode display.
// Optional leading-zero blanking via `BCD_SEG_LZ_BLANK_EN.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seg_scan_if.slave  bus
);

  localparam int IDX_W = idx_w(DIGITS);

  logic [4*DIGITS-1:0] snap;
  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic                div_wrap;
  logic                blank;
  logic [3:0]          nib;
  seg_t                seg_nxt;

  assign div_wrap = (div == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    nib = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IDX_W'(i)) nib = snap[4*i +: 4];
  end

`ifdef BCD_SEG_LZ_BLANK_EN
  // nz_above[i]: some nibble at position i or higher is non-zero (invalid codes count).
  logic [DIGITS:1]   nz_above;
  logic [DIGITS-1:0] blank_mask;

  assign nz_above[DIGITS] = 1'b0;
  assign blank_mask[0]    = 1'b0;
  for (genvar g = 1; g < DIGITS; g++) begin : g_lz
    assign nz_above[g]   = (snap[4*g +: 4] != 4'd0) | nz_above[g+1];
    assign blank_mask[g] = ~nz_above[g];
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IDX_W'(i)) blank = blank_mask[i];
  end
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_dec (
    .nib   (nib),
    .blank (blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap          <= '0;
      div           <= '0;
      idx           <= '0;
      bus.scan_tick <= 1'b0;
      bus.sel       <= '1;
      bus.seg       <= SEG_BLANK;
    end else begin
      if (bus.upd) snap <= bus.bcd_in;

      if (div_wrap) begin
        div           <= '0;
        bus.scan_tick <= 1'b1;
        idx           <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div           <= div + 1'b1;
        bus.scan_tick <= 1'b0;
      end

      // Output stage lags idx/snap by one clock so the pins are glitch-free.
      bus.sel <= ~(DIGITS'(1) << idx);
      bus.seg <= seg_nxt;
    end
  end

endmodule
